// File: rtl/idct_pkg.sv
// Shared widths and read-FSM state encoding for the IDCT coefficient feeder.
package idct_pkg;

  localparam int unsigned COEF_W  = 16;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned BLK_LEN = 64;
  localparam int unsigned IDX_W   = $clog2(BLK_LEN);
  localparam int unsigned ADDR_W  = IDX_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/idct_pp_ram.sv
// Ping-pong coefficient store: two banks addressed as {bank, index}.
// Read port is registered and returns zero when not enabled, so its
// output can drive the block output directly.
module idct_pp_ram
  import idct_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COEF_W-1:0] rd_data
);

  logic [COEF_W-1:0] mem [2*BLK_LEN];

  // Write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; idle cycles present zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/idct_feeder.sv
// Buffers 64-coefficient blocks in a ping-pong RAM and streams each full
// block to the IDCT core with a start pulse and a held block mode.
module idct_feeder
  import idct_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  input  logic [MODE_W-1:0] in_mode,
  input  logic              core_ready,
  output logic              start,
  output logic [COEF_W-1:0] x_out,
  output logic [MODE_W-1:0] mode_out,
  output logic              busy
);

  rd_state_e         state, state_nx;
  logic              wr_sel, rd_sel, rd_sel_nx;
  logic [IDX_W-1:0]  wr_cnt, rd_cnt, rd_cnt_nx;
  logic [1:0]        full, full_set, full_clr;
  logic [MODE_W-1:0] bank_mode [2];
  logic [MODE_W-1:0] mode_nx;
  logic              wr_en, rd_en, start_nx;
  logic [ADDR_W-1:0] rd_addr;

  assign in_ready = !full[wr_sel];
  assign wr_en    = in_valid && in_ready;

  idct_pp_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .wr_addr ({wr_sel, wr_cnt}),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (x_out)
  );

  // Write-side bank select and index.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel <= 1'b0;
      wr_cnt <= '0;
    end else if (wr_en) begin
      wr_cnt <= wr_cnt + IDX_W'(1);
      if (wr_cnt == LAST_IDX) begin
        wr_sel <= ~wr_sel;
      end
    end
  end

  // Block mode is captured with coefficient 0 only.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_cnt == '0)) begin
      bank_mode[wr_sel] <= in_mode;
    end
  end

  // Bank becomes full on its final write.
  always_comb begin
    full_set = '0;
    if (wr_en && (wr_cnt == LAST_IDX)) begin
      full_set[wr_sel] = 1'b1;
    end
  end

  // Fill and drain touch different banks, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      full <= (full & ~full_clr) | full_set;
    end
  end

  // Read FSM next state; the RAM is addressed one index ahead of x_out.
  always_comb begin
    state_nx  = state;
    rd_sel_nx = rd_sel;
    rd_cnt_nx = rd_cnt;
    rd_en     = 1'b0;
    rd_addr   = {rd_sel, rd_cnt};
    full_clr  = '0;
    start_nx  = 1'b0;
    mode_nx   = mode_out;
    case (state)
      IDLE: begin
        if (full[rd_sel] && core_ready) begin
          state_nx  = SEND;
          rd_en     = 1'b1;
          rd_addr   = {rd_sel, IDX_W'(0)};
          rd_cnt_nx = '0;
          start_nx  = 1'b1;
          mode_nx   = bank_mode[rd_sel];
        end
      end
      SEND: begin
        if (rd_cnt == LAST_IDX) begin
          state_nx         = IDLE;
          full_clr[rd_sel] = 1'b1;
          rd_sel_nx        = ~rd_sel;
          rd_cnt_nx        = '0;
        end else begin
          rd_en     = 1'b1;
          rd_addr   = {rd_sel, IDX_W'(rd_cnt + IDX_W'(1))};
          rd_cnt_nx = rd_cnt + IDX_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read FSM state and registered block outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_sel   <= 1'b0;
      rd_cnt   <= '0;
      start    <= 1'b0;
      mode_out <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_sel   <= rd_sel_nx;
      rd_cnt   <= rd_cnt_nx;
      start    <= start_nx;
      mode_out <= mode_nx;
      busy     <= (state_nx == SEND);
    end
  end

endmodule

// File: doc/idct_feeder.md
IDCT_FEEDER -- requirements
Module: idct_feeder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  upstream coefficient valid.
REQ-004 in_ready  output  1  feeder can accept a coefficient this cycle.
REQ-005 in_data  input  16  signed coefficient, row-major order, 64 per block.
REQ-006 in_mode  input  2  block mode; sampled only with the first coefficient of a block.
REQ-007 core_ready  input  1  IDCT core can accept a new block.
REQ-008 start  output  1  one-cycle pulse coincident with coefficient 0 of a block.
REQ-009 x_out  output  16  coefficient to the IDCT core.
REQ-010 mode_out  output  2  mode of the block being sent, held for all 64 cycles.
REQ-011 busy  output  1  high while in state SEND.

Function
REQ-012 Storage is two 64x16 banks (ping-pong), each with a full flag and a 2-bit stored mode.
- Write side: write bank select wr_sel, 6-bit counter wr_cnt.
REQ-013 in_ready = !full[wr_sel].
- in_ready is combinational from registers only; it does not depend on in_valid.
REQ-014 A write occurs when in_valid && in_ready: data stored at [wr_sel][wr_cnt], then wr_cnt increments.
- At wr_cnt==0, in_mode is captured into the bank mode.
REQ-015 On the write with wr_cnt==63:
- full[wr_sel] is set;
- wr_sel toggles;
- wr_cnt wraps to 0.
REQ-016 Read FSM has two states, IDLE and SEND.
- Read side: read bank select rd_sel, 6-bit counter rd_cnt.
REQ-017 IDLE -> SEND when full[rd_sel] && core_ready; core_ready is ignored outside IDLE.
REQ-018 Output timing for one block:
- First SEND cycle: start=1, x_out=coef0, mode_out=bank mode.
- Next 63 cycles: coef1..coef63, with start=0.
- Outputs are registered; a registered-read RAM is allowed provided this timing holds.
REQ-019 After the coef63 cycle:
- full[rd_sel] clears;
- rd_sel toggles;
- FSM returns to IDLE.
- Consecutive blocks are therefore separated by at least one idle cycle.
REQ-020 Outside SEND: start=0, x_out=0; mode_out holds its last value.
REQ-021 Fill and drain are independent and may occur in the same cycle; a set and a clear of different banks' full flags in one cycle both take effect.
REQ-022 Both banks full: in_ready=0 until the SEND of rd_sel completes.
- The freed bank is writable in the cycle after its full flag clears.
REQ-023 Maximum sustained throughput is one block per 65 cycles; there is no data loss or reordering under any valid/core_ready pattern.
REQ-024 Bank data is passed through unmodified; no arithmetic and no width change.

Reset
REQ-025 On rst, the following clear within the same edge: wr_sel, rd_sel, wr_cnt, rd_cnt, both full flags, and the FSM (to IDLE).
REQ-026 Reset values: start=0, x_out=0, mode_out=0, busy=0, in_ready=1 (from the cycle after reset).
REQ-027 Reset mid-fill or mid-send discards partial and stored blocks; RAM contents need no reset.

Structure
REQ-028 Shared package idct_pkg holds:
- COEF_W=16, MODE_W=2, BLK_LEN=64;
- the read FSM state enum (IDLE, SEND).
REQ-029 One sub-module, idct_pp_ram:
- 128x16, one write port, one registered read port;
- address = {bank, index}.

Verification
REQ-030 Single block: write 64 coefficients (value k at index k, mode=2'b01), core_ready=1 -> start pulse with x_out=0, then 1..63 on consecutive cycles; mode_out=01 throughout; busy high for 64 cycles.
REQ-031 Backpressure: core_ready=0, stream 128 coefficients, then keep in_valid=1 -> in_ready falls after write 128, both banks full; core_ready=1 -> block A sent, then block B after one idle cycle.
REQ-032 Overlap: send block A while block B streams in at full rate -> in_ready never drops; B starts exactly 65 cycles after A's start.
REQ-033 Mode capture: block with in_mode=3 on coef0 and 0 on all later coefficients -> mode_out=3 for that whole block.
REQ-034 Reset at rd_cnt=30 during SEND -> next cycle start=0, x_out=0, busy=0, in_ready=1; a new 64-coefficient block is sent correctly.
REQ-035 Random in_valid/core_ready, 50 blocks -> scoreboard shows all 3200 coefficients in order with correct modes.
